// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the 5-stage MIPS core: ALU-control decode, 32-bit ALU
// and a 64-word data memory that writes on the falling clock edge.
module exec_mem_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic [3:0]        aluOp,
  input  logic [5:0]        func,
  input  logic [31:0]       aluA,
  input  logic [31:0]       aluB,
  output logic [3:0]        aluCtrl,
  output logic [31:0]       aluOut,
  output logic              aluZero,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memWriteData,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [31:0]       memOut
);

  typedef enum logic [3:0] {
    OpAnd  = 4'b0000,
    OpOr   = 4'b0001,
    OpAdd  = 4'b0010,
    OpSll  = 4'b0011,
    OpSrl  = 4'b0100,
    OpSub  = 4'b0110,
    OpSlt  = 4'b0111,
    OpAddu = 4'b1000,
    OpSubu = 4'b1001,
    OpXor  = 4'b1010,
    OpSltu = 4'b1011,
    OpNor  = 4'b1100,
    OpSra  = 4'b1101,
    OpLui  = 4'b1110
  } aluOpE;

  localparam int Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];
  logic [4:0]  shamt;

  assign shamt = aluA[4:0];

  // R-type instructions defer to the func field; unknown funcs fall back to AND
  always_comb begin
    aluCtrl = aluOp;
    if (aluOp == 4'b1111) begin
      case (func)
        6'b000000: aluCtrl = OpSll;
        6'b000010: aluCtrl = OpSrl;
        6'b000011: aluCtrl = OpSra;
        6'b100000: aluCtrl = OpAdd;
        6'b100001: aluCtrl = OpAddu;
        6'b100010: aluCtrl = OpSub;
        6'b100011: aluCtrl = OpSubu;
        6'b100100: aluCtrl = OpAnd;
        6'b100101: aluCtrl = OpOr;
        6'b100110: aluCtrl = OpXor;
        6'b100111: aluCtrl = OpNor;
        6'b101010: aluCtrl = OpSlt;
        6'b101011: aluCtrl = OpSltu;
        default:   aluCtrl = OpAnd;
      endcase
    end
  end

  always_comb begin
    aluOut = 32'h0;
    case (aluCtrl)
      OpAnd:        aluOut = aluA & aluB;
      OpOr:         aluOut = aluA | aluB;
      OpAdd, OpAddu: aluOut = aluA + aluB;
      OpSub, OpSubu: aluOut = aluA - aluB;
      OpSlt:        aluOut = {31'h0, $signed(aluA) < $signed(aluB)};
      OpSltu:       aluOut = {31'h0, aluA < aluB};
      OpXor:        aluOut = aluA ^ aluB;
      OpNor:        aluOut = ~(aluA | aluB);
      OpSll:        aluOut = aluB << shamt;
      OpSrl:        aluOut = aluB >> shamt;
      OpSra:        aluOut = $signed(aluB) >>> shamt;
      OpLui:        aluOut = {aluB[15:0], 16'h0000};
      default:      aluOut = 32'h0;
    endcase
  end

  assign aluZero = (aluOut == 32'h0);

  // Reset wins over a write landing on the same edge, so a coincident store is dropped
  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 32'h0;
    end else if (memWrite) begin
      mem[memAddr] <= memWriteData;
    end
  end

  assign memOut = memRead ? mem[memAddr] : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed ALU vectors, randomized ALU and
// memory traffic against an arithmetic reference model, and reset corner cases.
module tb_exec_mem_unit;

  logic        CLK;
  logic        Reset_L;
  logic [3:0]  aluOp;
  logic [5:0]  func;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [3:0]  aluCtrl;
  logic [31:0] aluOut;
  logic        aluZero;
  logic [5:0]  memAddr;
  logic [31:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] refMem [64];

  exec_mem_unit #(.ADDR_W(6)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .aluOp(aluOp), .func(func), .aluA(aluA), .aluB(aluB),
    .aluCtrl(aluCtrl), .aluOut(aluOut), .aluZero(aluZero), .memAddr(memAddr),
    .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite), .memOut(memOut)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  expCtrl;
    logic [31:0] expOut;
  } vecT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    aluOp = op; func = fn; aluA = a; aluB = b;
    #1;
  endtask

  // Reference decode as a lookup table of (func, operation) pairs
  function automatic logic [3:0] refCtrl(input logic [3:0] op, input logic [5:0] fn);
    logic [5:0] fnList [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [3:0] opList [13] = '{4'd3, 4'd4, 4'd13, 4'd2, 4'd8, 4'd6, 4'd9,
                                4'd0, 4'd1, 4'd10, 4'd12, 4'd7, 4'd11};
    if (op != 4'hF) return op;
    for (int i = 0; i < 13; i++) if (fnList[i] == fn) return opList[i];
    return 4'h0;
  endfunction

  // Shifts modelled as multiply/divide by powers of two
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p = 1;
    longint sb = longint'(signed'(b));
    longint q;
    for (int i = 0; i < int'(a[4:0]); i++) p = p * 2;
    case (op)
      4'd0:       return a & b;
      4'd1:       return a | b;
      4'd2, 4'd8: return 32'(longint'(a) + longint'(b));
      4'd6, 4'd9: return 32'(longint'(a) - longint'(b));
      4'd7:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd11:      return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd10:      return a ^ b;
      4'd12:      return ~(a | b);
      4'd3:       return 32'(longint'(b) * p);
      4'd4:       return 32'(longint'(b) / p);
      4'd13: begin
        q = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
        return 32'(q);
      end
      4'd14:      return 32'(longint'(b[15:0]) * 65536);
      default:    return 32'h0;
    endcase
  endfunction

  task automatic checkAlu(input string tag, input logic [3:0] expCtrl, input logic [31:0] expOut);
    checkOutput({tag, ".ctrl"}, {28'h0, aluCtrl}, {28'h0, expCtrl});
    checkOutput({tag, ".out"}, aluOut, expOut);
    checkOutput({tag, ".zero"}, {31'h0, aluZero}, {31'h0, expOut == 32'h0});
  endtask

  // One memory cycle: drive after posedge, check before and after the falling edge
  task automatic memCycle(input logic [5:0] addr, input logic [31:0] data, input logic we, input logic re);
    @(posedge CLK); #1;
    memAddr = addr; memWriteData = data; memWrite = we; memRead = re;
    #1;
    checkOutput("mem.pre", memOut, re ? refMem[addr] : 32'h0);
    @(negedge CLK); #1;
    if (we) refMem[addr] = data;
    checkOutput("mem.post", memOut, re ? refMem[addr] : 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    memWrite = 1'b0; memRead = 1'b1;
    for (int i = 0; i < 64; i++) begin
      memAddr = 6'(i); #1;
      checkOutput(tag, memOut, 32'h0);
    end
  endtask

  vecT vecs[12];

  initial begin
    vecs[0]  = '{4'hF, 6'h20, 32'd7, 32'd5, 4'd2, 32'd12};
    vecs[1]  = '{4'hF, 6'h22, 32'd5, 32'd5, 4'd6, 32'd0};
    vecs[2]  = '{4'hF, 6'h2A, 32'hFFFFFFFF, 32'd1, 4'd7, 32'd1};
    vecs[3]  = '{4'hF, 6'h2B, 32'hFFFFFFFF, 32'd1, 4'd11, 32'd0};
    vecs[4]  = '{4'hF, 6'h03, 32'd4, 32'h80000000, 4'd13, 32'hF8000000};
    vecs[5]  = '{4'hF, 6'h02, 32'd4, 32'h80000000, 4'd4, 32'h08000000};
    vecs[6]  = '{4'hE, 6'h00, 32'hFFFF0000, 32'h00001234, 4'd14, 32'h12340000};
    vecs[7]  = '{4'h1, 6'h20, 32'h0F0F0000, 32'h000000F0, 4'd1, 32'h0F0F00F0};
    vecs[8]  = '{4'hF, 6'h3F, 32'hFF00FF00, 32'h0FF00FF0, 4'd0, 32'h0F000F00};
    vecs[9]  = '{4'h5, 6'h00, 32'd3, 32'd4, 4'd5, 32'h0};
    vecs[10] = '{4'hF, 6'h27, 32'h0000FFFF, 32'hFFFF0000, 4'd12, 32'h0};
    vecs[11] = '{4'hF, 6'h00, 32'd36, 32'h00000003, 4'd3, 32'h00000030};

    Reset_L = 1'b0;
    aluOp = 4'h0; func = 6'h0; aluA = 32'h0; aluB = 32'h0;
    memAddr = 6'h0; memWriteData = 32'h0; memRead = 1'b1; memWrite = 1'b0;
    for (int i = 0; i < 64; i++) refMem[i] = 32'h0;

    // ALU must work while reset is held
    applyStimulus(4'hF, 6'h20, 32'd7, 32'd5);
    checkAlu("alu.inReset", 4'd2, 32'd12);
    checkOutput("mem.resetRead", memOut, 32'h0);
    #12 Reset_L = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      checkAlu($sformatf("vec%0d", i), vecs[i].expCtrl, vecs[i].expOut);
    end

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [5:0] fn;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      fn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        logic [5:0] legal [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                   6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        fn = legal[$urandom_range(0, 12)];
      end
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      applyStimulus(op, fn, a, b);
      checkAlu("rnd", refCtrl(op, fn), refAlu(refCtrl(op, fn), a, b));
    end

    memCycle(6'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    memCycle(6'd5, 32'h0, 1'b0, 1'b1);
    memCycle(6'd5, 32'h0, 1'b0, 1'b0);
    memCycle(6'd63, 32'hA5A5A5A5, 1'b1, 1'b1);
    memCycle(6'd63, 32'h0, 1'b0, 1'b1);
    memCycle(6'd0, 32'h13579BDF, 1'b1, 1'b1);
    memCycle(6'd0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++)
      memCycle(6'($urandom), $urandom, 1'($urandom), 1'($urandom));

    // Reset pulse mid-cycle while a write is pending across the falling edge
    @(posedge CLK); #1;
    memAddr = 6'd9; memWriteData = 32'hCAFEF00D; memWrite = 1'b1; memRead = 1'b1;
    #1 Reset_L = 1'b0;
    @(negedge CLK); #1;
    checkOutput("reset.blockWrite", memOut, 32'h0);
    #2 Reset_L = 1'b1;
    for (int i = 0; i < 64; i++) refMem[i] = 32'h0;
    checkAllZero("reset.clear");

    memCycle(6'd17, 32'h11112222, 1'b1, 1'b1);
    // Reset asserted on the falling edge itself must still leave memory clear
    @(posedge CLK); #1;
    memAddr = 6'd17; memWriteData = 32'h33334444; memWrite = 1'b1; memRead = 1'b1;
    @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    checkOutput("reset.coincident", memOut, 32'h0);
    #2 Reset_L = 1'b1;
    for (int i = 0; i < 64; i++) refMem[i] = 32'h0;
    checkAllZero("reset.clear2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
